// File: rtl/pkg_panel.sv
// Shared panel definitions: image-buffer address map, geometry defaults and the
// buffer write payload. The serial driver imports this package as well.
package pkg_panel;

    localparam int unsigned ADDR_W       = 13;
    localparam int unsigned ROW_W        = 8;
    localparam int unsigned COL_W        = 5;
    localparam int unsigned PIX_W        = 30;
    localparam int unsigned H_ACTIVE_DEF = 16;
    localparam int unsigned V_ACTIVE_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_DROP_LINE = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } buf_wr_t;

    // Buffer address of a pixel: row in the upper bits, column in the lower bits.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/pixel_stream_writer.sv
// Converts a raster-ordered valid/ready pixel stream into image-buffer write
// strobes, tracking row/column and flagging frame-geometry errors.
module pixel_stream_writer
    import pkg_panel::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              iSysclk,
    input  logic              iReset,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iSof,
    input  logic              iEol,
    input  logic [PIX_W-1:0]  iPixel,
    output logic              oWREN,
    output logic [PIX_W-1:0]  oImage,
    output logic [ADDR_W-1:0] oAddress,
    output logic              oFrameDone,
    output logic              oLineErr,
    output logic              oFrameErr,
    input  logic              iErrClr
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_ACTIVE - 1);

    wr_state_t          state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               ready_q;
    logic               wren_q, wren_d;
    buf_wr_t            wr_q, wr_d;
    logic               done_q, done_d;
    logic               line_err_q, frame_err_q;
    logic               line_set, frame_set;
    logic               do_write;
    logic [ROW_W-1:0]   eff_row;
    logic [COL_W-1:0]   eff_col;
    logic               xfer;

    assign xfer = iValid & ready_q;

    // Next state, counters and write payload for the accepted pixel.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wren_d    = 1'b0;
        wr_d      = wr_q;
        done_d    = 1'b0;
        line_set  = 1'b0;
        frame_set = 1'b0;
        do_write  = 1'b0;
        eff_row   = row_q;
        eff_col   = col_q;

        if (xfer) begin
            if (iSof) begin
                // A sof always restarts at (0,0); mid-frame it is also an error.
                frame_set = (state_q != ST_IDLE);
                eff_row   = '0;
                eff_col   = '0;
                do_write  = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: frame_set = 1'b1;
                    ST_ACTIVE: do_write = 1'b1;
                    ST_DROP_LINE: begin
                        line_set = 1'b1;
                        if (iEol) begin
                            if (row_q == LAST_ROW) begin
                                state_d = ST_IDLE;
                                row_d   = '0;
                                col_d   = '0;
                            end else begin
                                state_d = ST_ACTIVE;
                                row_d   = row_q + ROW_W'(1);
                                col_d   = '0;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            if (do_write) begin
                wren_d  = 1'b1;
                wr_d.addr = pix_addr(eff_row, eff_col);
                wr_d.data = iPixel;
                if (iEol) begin
                    line_set = (eff_col != LAST_COL);
                    if (eff_row == LAST_ROW) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        state_d = ST_ACTIVE;
                        row_d   = eff_row + ROW_W'(1);
                        col_d   = '0;
                    end
                end else if (eff_col == LAST_COL) begin
                    state_d = ST_DROP_LINE;
                    row_d   = eff_row;
                    col_d   = eff_col;
                end else begin
                    state_d = ST_ACTIVE;
                    row_d   = eff_row;
                    col_d   = eff_col + COL_W'(1);
                end
            end
        end
    end

    // State, counters, output stage and sticky error flags.
    always_ff @(posedge iSysclk) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            ready_q     <= 1'b0;
            wren_q      <= 1'b0;
            wr_q        <= '0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ready_q     <= 1'b1;
            wren_q      <= wren_d;
            wr_q        <= wr_d;
            done_q      <= done_d;
            line_err_q  <= (line_err_q & ~iErrClr) | line_set;
            frame_err_q <= (frame_err_q & ~iErrClr) | frame_set;
        end
    end

    assign oReady     = ready_q;
    assign oWREN      = wren_q;
    assign oImage     = wr_q.data;
    assign oAddress   = wr_q.addr;
    assign oFrameDone = done_q;
    assign oLineErr   = line_err_q;
    assign oFrameErr  = frame_err_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed self-checking bench for pixel_stream_writer (H=16, V=240).
module tb_pixel_stream_writer;

    localparam int unsigned H = 16;
    localparam int unsigned V = 240;

    logic        iSysclk = 1'b0;
    logic        iReset  = 1'b1;
    logic        iValid  = 1'b0;
    logic        oReady;
    logic        iSof    = 1'b0;
    logic        iEol    = 1'b0;
    logic [29:0] iPixel  = '0;
    logic        oWREN;
    logic [29:0] oImage;
    logic [12:0] oAddress;
    logic        oFrameDone;
    logic        oLineErr;
    logic        oFrameErr;
    logic        iErrClr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_stream_writer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .iSysclk   (iSysclk),
        .iReset    (iReset),
        .iValid    (iValid),
        .oReady    (oReady),
        .iSof      (iSof),
        .iEol      (iEol),
        .iPixel    (iPixel),
        .oWREN     (oWREN),
        .oImage    (oImage),
        .oAddress  (oAddress),
        .oFrameDone(oFrameDone),
        .oLineErr  (oLineErr),
        .oFrameErr (oFrameErr),
        .iErrClr   (iErrClr)
    );

    always #5 iSysclk = ~iSysclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] pdat(input int r, input int c, input int k);
        return 30'(r * 4096 + c * 64 + k);
    endfunction

    // One clock with the given inputs; returns #1 after the edge, outputs settled.
    task automatic cyc(input logic v, input logic s, input logic e, input logic [29:0] p);
        iValid = v;
        iSof   = s;
        iEol   = e;
        iPixel = p;
        @(posedge iSysclk);
        #1;
        iValid = 1'b0;
        iSof   = 1'b0;
        iEol   = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input int r, input int c,
                             input logic [29:0] d, input logic done);
        check({tag, "_wren"}, 64'(oWREN), 64'(1));
        check({tag, "_addr"}, 64'(oAddress), 64'(r * 32 + c));
        check({tag, "_data"}, 64'(oImage), 64'(d));
        check({tag, "_done"}, 64'(oFrameDone), 64'(done));
    endtask

    // Sends n pixels of row r (sof on row 0 col 0, eol on the last if eol=1).
    task automatic send_row(input int r, input int n, input logic eol, input int k);
        logic [29:0] d;
        for (int c = 0; c < n; c++) begin
            d = pdat(r, c, k);
            cyc(1'b1, (r == 0 && c == 0), (eol && c == n - 1), d);
            if (c < int'(H)) begin
                expect_wr("row", r, c, d, (r == int'(V) - 1 && eol && c == n - 1));
            end else begin
                check("drop_wren", 64'(oWREN), 64'(0));
                check("drop_done", 64'(oFrameDone), 64'(0));
            end
        end
    endtask

    task automatic clear_errs();
        iErrClr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0);
        iErrClr = 1'b0;
    endtask

    initial begin
        logic [29:0] d;
        int gaps;

        // Reset state
        repeat (3) @(posedge iSysclk);
        #1;
        check("rst_ready", 64'(oReady), 64'(0));
        check("rst_wren",  64'(oWREN), 64'(0));
        check("rst_image", 64'(oImage), 64'(0));
        check("rst_addr",  64'(oAddress), 64'(0));
        check("rst_done",  64'(oFrameDone), 64'(0));
        check("rst_lerr",  64'(oLineErr), 64'(0));
        check("rst_ferr",  64'(oFrameErr), 64'(0));
        iReset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("ready_up", 64'(oReady), 64'(1));

        // Pixels before any sof are dropped and flag a frame error
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 30'(i + 1));
            check("nosof_wren", 64'(oWREN), 64'(0));
        end
        check("nosof_ferr", 64'(oFrameErr), 64'(1));
        clear_errs();
        check("clr_ferr", 64'(oFrameErr), 64'(0));
        iErrClr = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 30'h5);
        iErrClr = 1'b0;
        check("clr_vs_new_ferr", 64'(oFrameErr), 64'(1));
        clear_errs();
        check("clr2_ferr", 64'(oFrameErr), 64'(0));

        // Full frame, iValid every cycle
        for (int r = 0; r < int'(V); r++) send_row(r, int'(H), 1'b1, 1);
        check("full_lerr", 64'(oLineErr), 64'(0));
        check("full_ferr", 64'(oFrameErr), 64'(0));
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("full_idle_wren", 64'(oWREN), 64'(0));
        check("full_idle_done", 64'(oFrameDone), 64'(0));

        // Short line at row 5; frame still completes
        for (int r = 0; r < 5; r++) send_row(r, int'(H), 1'b1, 2);
        send_row(5, 10, 1'b1, 2);
        check("short_lerr", 64'(oLineErr), 64'(1));
        check("short_ferr", 64'(oFrameErr), 64'(0));
        for (int r = 6; r < int'(V); r++) send_row(r, int'(H), 1'b1, 2);
        clear_errs();
        check("short_clr_lerr", 64'(oLineErr), 64'(0));

        // Long line: 20 pixels, only cols 0..15 written, next row at col 0
        send_row(0, 20, 1'b1, 3);
        check("long_lerr", 64'(oLineErr), 64'(1));
        for (int r = 1; r < 100; r++) send_row(r, int'(H), 1'b1, 3);
        check("long_ferr", 64'(oFrameErr), 64'(0));

        // Sof mid-frame at row 100 col 3
        send_row(100, 3, 1'b0, 3);
        d = 30'h2AAAAAAA;
        cyc(1'b1, 1'b1, 1'b0, d);
        expect_wr("midsof0", 0, 0, d, 1'b0);
        check("midsof_ferr", 64'(oFrameErr), 64'(1));
        d = 30'h15555555;
        cyc(1'b1, 1'b0, 1'b0, d);
        expect_wr("midsof1", 0, 1, d, 1'b0);

        // Reset mid-line at row 7 col 4
        for (int r = 0; r < 7; r++) send_row(r, int'(H), 1'b1, 4);
        send_row(7, 4, 1'b0, 4);
        iReset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, pdat(7, 4, 4));
        iReset = 1'b0;
        check("mrst_wren",  64'(oWREN), 64'(0));
        check("mrst_addr",  64'(oAddress), 64'(0));
        check("mrst_image", 64'(oImage), 64'(0));
        check("mrst_ready", 64'(oReady), 64'(0));
        check("mrst_ferr",  64'(oFrameErr), 64'(0));
        check("mrst_lerr",  64'(oLineErr), 64'(0));
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("mrst_ready_up", 64'(oReady), 64'(1));
        cyc(1'b1, 1'b0, 1'b0, 30'h123);
        check("mrst_nosof_wren", 64'(oWREN), 64'(0));
        check("mrst_nosof_ferr", 64'(oFrameErr), 64'(1));

        // Sof frame with random iValid gaps
        for (int i = 0; i < 3 * int'(H); i++) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                cyc(1'b0, 1'b0, 1'b0, 30'h3FFFFFFF);
                check("gap_wren", 64'(oWREN), 64'(0));
            end
            d = pdat(i / int'(H), i % int'(H), 5);
            cyc(1'b1, (i == 0), (i % int'(H) == int'(H) - 1), d);
            expect_wr("gap", i / int'(H), i % int'(H), d, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
